prim_flop_pipe: RTL and testbench
=================================

PRIM_FLOP_PIPE -- requirements
Module: prim_flop_pipe

Interface
REQ-001 SHALL have parameter Width, default 1: data bits per stage, Width >= 1.
REQ-002 SHALL have parameter Depth, default 2: number of pipeline stages, Depth >= 1; elaboration error otherwise.
REQ-003 SHALL have parameter ResetValue, default 0: Width-bit data value of every stage after reset or clear.
REQ-004 SHALL have parameter EnSecBuf, default 0: when 1, en_i and clr_i each pass through a clock-buffer cell before use.
REQ-005 SHALL have port clk_i  input  1: single clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port en_i  input  1: advance; all stages shift by one when high.
REQ-008 SHALL have port clr_i  input  1: synchronous flush of all stages.
REQ-009 SHALL have port valid_i  input  1: qualifier for d_i.
REQ-010 SHALL have port d_i  input  Width: data into stage 0.
REQ-011 SHALL have port valid_o  output  1: valid bit of stage Depth-1.
REQ-012 SHALL have port q_o  output  Width: data of stage Depth-1.
REQ-013 SHALL have port cnt_o  output  CntW = $clog2(Depth+1): number of valid stages.
REQ-014 SHALL have port err_o  output  1: integrity error flag (see Configuration).

Function
REQ-015 Each stage SHALL hold a data register and a valid bit; all outputs registered, no combinational path from inputs to outputs.
REQ-016 When en_i=1 and clr_i=0: stage0 <= {valid_i, d_i}, stage k <= stage k-1 for k=1..Depth-1, in one edge.
REQ-017 When en_i=0 and clr_i=0: all stages SHALL hold; no data lost regardless of valid_i.
REQ-018 Latency SHALL be exactly Depth enabled cycles from d_i sampled to q_o; disabled cycles do not count.
REQ-019 clr_i=1 SHALL override en_i: all valid bits <= 0, all data <= ResetValue, cnt_o <= 0 at next edge.
REQ-020 Data of invalid samples SHALL still propagate (valid is a qualifier, not a gate).
REQ-021 cnt_o SHALL be a registered counter: on an enabled edge next = cnt + valid_i - valid_o; otherwise hold.
REQ-022 Simultaneous valid_i=1 and valid_o=1 on enable SHALL leave cnt_o unchanged; counter never wraps (range 0..Depth by construction).
REQ-023 For Depth=1, q_o/valid_o SHALL be stage0 and cnt_o SHALL equal valid_o.

Reset
REQ-024 rst_ni low SHALL asynchronously force all data to ResetValue, all valid bits and cnt_o to 0, err_o to 0.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight samples; first enabled edge after deassertion behaves as REQ-016.

Configuration
REQ-026 Macro PRIM_FLOP_PIPE_SHADOW_EN defined: each stage SHALL keep an inverted shadow copy of {valid,data} and a shadow counter, updated identically; err_o SHALL be asserted (registered, one cycle after detection) whenever any primary/shadow pair is not bitwise complementary, or cnt_o differs from popcount of valid bits; err_o sticky until rst_ni.
REQ-027 Macro not defined: no shadow storage, err_o tied 0.

Structure
REQ-028 Package prim_flop_pipe_pkg SHALL hold the CntW computation function and the stage typedef (valid bit plus data) parametrised via the package function.
REQ-029 Each stage SHALL be an instance of the existing enabled-flop primitive prim_flop_en (Width+1 bits, reset value {1'b0, ResetValue}); counter and shadow logic in prim_flop_pipe.

Verification
REQ-030 Width=8, Depth=3: en_i=1 constant, valid_i=1 with d_i=0x11,0x22,0x33 -> q_o=0x11 valid_o=1 on 3rd edge after first sample, cnt_o=3 after 3 edges.
REQ-031 Fill Depth=3, then en_i=0 for 5 cycles toggling d_i -> q_o, valid_o, cnt_o unchanged; resume en_i -> sequence continues in order.
REQ-032 Full pipe, clr_i=1 and en_i=1 same edge -> next cycle valid_o=0, cnt_o=0, q_o=ResetValue.
REQ-033 Alternating valid_i 1,0,1,0 with en_i=1 -> valid_o pattern 1,0,1,0 after 3 cycles, cnt_o oscillates 1/2 never exceeding 3.
REQ-034 rst_ni pulsed low mid-stream between edges -> outputs at reset values immediately, before next clk_i edge.
REQ-035 With PRIM_FLOP_PIPE_SHADOW_EN: force one shadow bit of stage 1 -> err_o=1 next cycle and remains 1 until reset; without macro err_o=0 throughout.

Source files
------------

// File: rtl/prim_flop_pipe_pkg.sv
// prim_flop_pipe_pkg: width helpers shared by the flop pipeline and its stages.
package prim_flop_pipe_pkg;
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int unsigned stage_w(input int unsigned width);
    return width + 1;
  endfunction
endpackage

// File: rtl/prim_clock_buf.sv
// prim_clock_buf: stand-in for the technology clock-buffer cell used on control lines.
module prim_clock_buf (
  input  logic in_i,
  output logic out_o
);
  assign out_o = in_i;
endmodule

// File: rtl/prim_flop_en.sv
// prim_flop_en: enabled register with asynchronous active-low reset.
module prim_flop_en #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] r_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_q <= ResetValue;
    else if (en_i) r_q <= d_i;
  end
  assign q_o = r_q;
endmodule

// File: rtl/prim_flop_pipe.sv
// prim_flop_pipe: enabled, clearable pipeline of {valid,data} stages with an occupancy counter.
// Define PRIM_FLOP_PIPE_SHADOW_EN to add inverted shadow copies and a sticky integrity error.
module prim_flop_pipe
  import prim_flop_pipe_pkg::*;
#(
  parameter int unsigned      Width      = 1,
  parameter int unsigned      Depth      = 2,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter bit               EnSecBuf   = 1'b0,
  localparam int unsigned     CntW       = cnt_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            valid_i,
  input  logic [Width-1:0] d_i,
  output logic            valid_o,
  output logic [Width-1:0] q_o,
  output logic [CntW-1:0] cnt_o,
  output logic            err_o
);
  localparam int unsigned SW = stage_w(Width);
  typedef logic [SW-1:0] stage_t;
  localparam stage_t RstStage = {1'b0, ResetValue};
  if (Depth < 1) begin : g_bad_depth
    $error("prim_flop_pipe: Depth must be >= 1");
  end
  logic w_en_b, w_clr_b, w_en, w_vo;
  stage_t w_d [Depth];
  stage_t w_q [Depth];
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  if (EnSecBuf) begin : g_secbuf
    prim_clock_buf u_en_buf  (.in_i(en_i),  .out_o(w_en_b));
    prim_clock_buf u_clr_buf (.in_i(clr_i), .out_o(w_clr_b));
  end else begin : g_nobuf
    assign w_en_b  = en_i;
    assign w_clr_b = clr_i;
  end
  assign w_en = w_en_b | w_clr_b;
  for (genvar i = 0; i < Depth; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign w_d[i] = w_clr_b ? RstStage : {valid_i, d_i};
    end else begin : g_next
      assign w_d[i] = w_clr_b ? RstStage : w_q[i-1];
    end
    prim_flop_en #(
      .Width     (SW),
      .ResetValue(RstStage)
    ) u_stage (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (w_en),
      .d_i   (w_d[i]),
      .q_o   (w_q[i])
    );
  end
  assign w_vo    = w_q[Depth-1][SW-1];
  assign valid_o = w_vo;
  assign q_o     = w_q[Depth-1][Width-1:0];
  assign w_cnt_nxt = w_clr_b ? '0 :
                     w_en_b  ? r_cnt + CntW'(valid_i) - CntW'(w_vo) : r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else r_cnt <= w_cnt_nxt;
  end
  assign cnt_o = r_cnt;
`ifdef PRIM_FLOP_PIPE_SHADOW_EN
  stage_t r_sh [Depth];
  logic [CntW-1:0] r_cnt_sh, w_pop;
  logic r_err, w_mis;
  // Shadows hold the complement so a stuck or flipped bit breaks the pairing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) r_sh[k] <= ~RstStage;
      r_cnt_sh <= '1;
      r_err    <= 1'b0;
    end else begin
      if (w_en) for (int k = 0; k < Depth; k++) r_sh[k] <= ~w_d[k];
      r_cnt_sh <= ~w_cnt_nxt;
      r_err    <= r_err | w_mis;
    end
  end
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < Depth; k++) w_pop = w_pop + CntW'(w_q[k][SW-1]);
  end
  always_comb begin
    w_mis = (r_cnt_sh != ~r_cnt) || (w_pop != r_cnt);
    for (int k = 0; k < Depth; k++) w_mis = w_mis || (r_sh[k] != ~w_q[k]);
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_prim_flop_pipe.sv
// tb_prim_flop_pipe: directed checks of fill, hold, clear, valid qualification and async reset.
module tb_prim_flop_pipe;
  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam logic [W-1:0] RV = 8'hA5;
  logic clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, clr_i = 1'b0, valid_i = 1'b0;
  logic [W-1:0] d_i = '0;
  logic valid_o, err_o;
  logic [W-1:0] q_o;
  logic [1:0] cnt_o;
  int vectors = 0, miscompares = 0;
  prim_flop_pipe #(.Width(W), .Depth(D), .ResetValue(RV), .EnSecBuf(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clr_i(clr_i), .valid_i(valid_i),
    .d_i(d_i), .valid_o(valid_o), .q_o(q_o), .cnt_o(cnt_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({valid_o, q_o, cnt_o, err_o} !== {1'b0, RV, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got v=%b q=%h cnt=%0d err=%b want v=0 q=%h cnt=0 err=0", valid_o, q_o, cnt_o, err_o, RV);
    end
    rst_ni = 1'b1;
    step();
  endtask
  task automatic test_fill();
    logic [W-1:0] dv [3] = '{8'h11, 8'h22, 8'h33};
    logic [W-1:0] eq [3] = '{RV, RV, 8'h11};
    logic ev [3] = '{1'b0, 1'b0, 1'b1};
    en_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i = dv[i];
      step();
      vectors++;
      if ({valid_o, q_o, cnt_o} !== {ev[i], eq[i], 2'(i + 1)}) begin
        miscompares++;
        $display("FAIL fill[%0d]: got v=%b q=%h cnt=%0d want v=%b q=%h cnt=%0d", i, valid_o, q_o, cnt_o, ev[i], eq[i], i + 1);
      end
    end
  endtask
  task automatic test_hold();
    logic [W-1:0] eq [3] = '{8'h22, 8'h33, 8'h44};
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_i = 8'hF0 ^ 8'(i * 37);
      valid_i = i[0];
      step();
      vectors++;
      if ({valid_o, q_o, cnt_o} !== {1'b1, 8'h11, 2'd3}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got v=%b q=%h cnt=%0d want v=1 q=11 cnt=3", i, valid_o, q_o, cnt_o);
      end
    end
    en_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i = 8'h44 + 8'(i * 17);
      step();
      vectors++;
      if ({valid_o, q_o, cnt_o} !== {1'b1, eq[i], 2'd3}) begin
        miscompares++;
        $display("FAIL resume[%0d]: got v=%b q=%h cnt=%0d want v=1 q=%h cnt=3", i, valid_o, q_o, cnt_o, eq[i]);
      end
    end
  endtask
  task automatic test_clear();
    clr_i = 1'b1;
    en_i = 1'b1;
    valid_i = 1'b1;
    d_i = 8'h99;
    step();
    clr_i = 1'b0;
    en_i = 1'b0;
    vectors++;
    if ({valid_o, q_o, cnt_o} !== {1'b0, RV, 2'd0}) begin
      miscompares++;
      $display("FAIL clear: got v=%b q=%h cnt=%0d want v=0 q=%h cnt=0", valid_o, q_o, cnt_o, RV);
    end
  endtask
  task automatic test_alternate();
    logic ev [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] ec [6] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    logic [W-1:0] eq;
    en_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = ~i[0];
      d_i = 8'h10 + 8'(i);
      step();
      eq = (i < 2) ? RV : 8'h10 + 8'(i - 2);
      vectors++;
      if ({valid_o, q_o, cnt_o} !== {ev[i], eq, ec[i]}) begin
        miscompares++;
        $display("FAIL alternate[%0d]: got v=%b q=%h cnt=%0d want v=%b q=%h cnt=%0d", i, valid_o, q_o, cnt_o, ev[i], eq, ec[i]);
      end
    end
  endtask
  task automatic test_async_reset();
    logic [W-1:0] eq [3] = '{RV, RV, 8'h77};
    logic ev [3] = '{1'b0, 1'b0, 1'b1};
    en_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i = 8'h50 + 8'(i);
      step();
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if ({valid_o, q_o, cnt_o, err_o} !== {1'b0, RV, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b q=%h cnt=%0d err=%b want v=0 q=%h cnt=0 err=0", valid_o, q_o, cnt_o, err_o, RV);
    end
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i = 8'h77 + 8'(i);
      step();
      vectors++;
      if ({valid_o, q_o, cnt_o} !== {ev[i], eq[i], 2'(i + 1)}) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: got v=%b q=%h cnt=%0d want v=%b q=%h cnt=%0d", i, valid_o, q_o, cnt_o, ev[i], eq[i], i + 1);
      end
    end
  endtask
  task automatic test_shadow();
`ifdef PRIM_FLOP_PIPE_SHADOW_EN
    en_i = 1'b0;
    force dut.r_sh[1] = '0;
    step();
    release dut.r_sh[1];
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (err_o !== 1'b1) begin
        miscompares++;
        $display("FAIL shadow_err[%0d]: got err=%b want 1", i, err_o);
      end
    end
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    step();
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL shadow_clear: got err=%b want 0", err_o);
    end
`else
    for (int i = 0; i < 4; i++) begin
      en_i = i[0];
      valid_i = i[1];
      step();
      vectors++;
      if (err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL err_tied[%0d]: got err=%b want 0", i, err_o);
      end
    end
`endif
  endtask
  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_clear();
    test_alternate();
    test_async_reset();
    test_shadow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
